// File: rtl/set_assoc_cache.sv
// set_assoc_cache: N-way set-associative, write-back, write-allocate line cache
// with tree pseudo-LRU replacement between a 256-bit CPU line port and memory.
//
// state     | meaning
// ----------+------------------------------------------------------------
// CHECK     | tag compare; serve hits, pick a victim and launch a miss
// WRITEBACK | write the dirty victim line back to memory
// FILL      | fetch the requested line into the victim way
module set_assoc_cache #(
    parameter int S_INDEX = 4,
    parameter int WAYS    = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [31:0]  i_mem_address,
    input  logic         i_mem_read,
    input  logic         i_mem_write,
    input  logic [31:0]  i_mem_byte_enable,
    input  logic [255:0] i_mem_wdata,
    output logic [255:0] o_mem_rdata,
    output logic         o_mem_resp,
    output logic [31:0]  o_pmem_address,
    output logic         o_pmem_read,
    output logic         o_pmem_write,
    output logic [255:0] o_pmem_wdata,
    input  logic [255:0] i_pmem_rdata,
    input  logic         i_pmem_resp
);

    localparam int SETS   = 2 ** S_INDEX;
    localparam int TAG_W  = 27 - S_INDEX;
    localparam int WAY_W  = $clog2(WAYS);
    localparam int PLRU_W = WAYS - 1;

    typedef enum logic [1:0] {
        CHECK     = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [TAG_W-1:0]  r_tag   [WAYS][SETS];
    logic [255:0]      r_data  [WAYS][SETS];
    logic [SETS-1:0]   r_valid [WAYS];
    logic [SETS-1:0]   r_dirty [WAYS];
    logic [PLRU_W-1:0] r_plru  [SETS];
    logic [WAY_W-1:0]  r_victim;

    logic [S_INDEX-1:0] w_index;
    logic [TAG_W-1:0]   w_tag;
    logic               w_req;
    logic               w_hit;
    logic [WAY_W-1:0]   w_hit_way;
    logic               w_hit_access;
    logic [PLRU_W-1:0]  w_plru_set;
    logic [PLRU_W-1:0]  w_plru_upd;
    logic [WAY_W-1:0]   w_plru_victim;
    logic [WAY_W-1:0]   w_victim_sel;
    logic               w_fill_done;
    logic               w_unused;

    assign w_index      = i_mem_address[4+S_INDEX:5];
    assign w_tag        = i_mem_address[31:5+S_INDEX];
    // a simultaneous read and write is handled as a write, so mem_write alone selects the op
    assign w_req        = i_mem_read | i_mem_write;
    assign w_hit_access = (r_state == CHECK) && w_req && w_hit;
    assign w_fill_done  = (r_state == FILL) && i_pmem_resp;
    assign w_plru_set   = r_plru[w_index];
    assign w_unused     = ^i_mem_address[4:0];

    // tag compare across all ways of the addressed set
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w][w_index] && (r_tag[w][w_index] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
    end

    // tree walk: way w is the PLRU victim when every node on its path points toward it
    always_comb begin
        logic v_match;
        w_plru_victim = '0;
        v_match       = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            v_match = 1'b1;
            for (int lvl = 0; lvl < WAY_W; lvl++) begin
                if (w_plru_set[(1 << lvl) - 1 + (w >> (WAY_W - lvl))] !=
                    1'((w >> (WAY_W - 1 - lvl)) & 1)) begin
                    v_match = 1'b0;
                end
            end
            if (v_match) begin
                w_plru_victim = WAY_W'(w);
            end
        end
    end

    // victim choice: lowest invalid way first, otherwise the PLRU way
    always_comb begin
        logic v_found;
        v_found      = 1'b0;
        w_victim_sel = w_plru_victim;
        for (int w = 0; w < WAYS; w++) begin
            if (!v_found && !r_valid[w][w_index]) begin
                w_victim_sel = WAY_W'(w);
                v_found      = 1'b1;
            end
        end
    end

    // PLRU update for the hit way: each node on its path points away from it
    always_comb begin
        w_plru_upd = w_plru_set;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            for (int j = 0; j < (1 << lvl); j++) begin
                if ((int'(w_hit_way) >> (WAY_W - lvl)) == j) begin
                    w_plru_upd[(1 << lvl) - 1 + j] = ~w_hit_way[WAY_W-1-lvl];
                end
            end
        end
    end

    // next-state and port outputs
    always_comb begin
        w_state_next   = r_state;
        o_mem_resp     = 1'b0;
        o_mem_rdata    = '0;
        o_pmem_read    = 1'b0;
        o_pmem_write   = 1'b0;
        o_pmem_address = '0;
        o_pmem_wdata   = '0;
        case (r_state)
            CHECK: begin
                if (w_req && !i_rst) begin
                    if (w_hit) begin
                        o_mem_resp  = 1'b1;
                        o_mem_rdata = r_data[w_hit_way][w_index];
                    end else if (r_valid[w_victim_sel][w_index] &&
                                 r_dirty[w_victim_sel][w_index]) begin
                        w_state_next = WRITEBACK;
                    end else begin
                        w_state_next = FILL;
                    end
                end
            end
            WRITEBACK: begin
                o_pmem_write   = 1'b1;
                o_pmem_address = {r_tag[r_victim][w_index], w_index, 5'b0};
                o_pmem_wdata   = r_data[r_victim][w_index];
                if (i_pmem_resp) begin
                    w_state_next = FILL;
                end
            end
            FILL: begin
                o_pmem_read    = 1'b1;
                o_pmem_address = {w_tag, w_index, 5'b0};
                if (i_pmem_resp) begin
                    w_state_next = CHECK;
                end
            end
            default: w_state_next = CHECK;
        endcase
    end

    // state, victim latch and the resettable valid/dirty/PLRU bookkeeping
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= CHECK;
            r_victim <= '0;
            for (int w = 0; w < WAYS; w++) begin
                r_valid[w] <= '0;
                r_dirty[w] <= '0;
            end
            for (int s = 0; s < SETS; s++) begin
                r_plru[s] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            if ((r_state == CHECK) && w_req && !w_hit) begin
                r_victim <= w_victim_sel;
            end
            if (w_hit_access) begin
                r_plru[w_index] <= w_plru_upd;
                if (i_mem_write) begin
                    r_dirty[w_hit_way][w_index] <= 1'b1;
                end
            end
            if (w_fill_done) begin
                r_valid[r_victim][w_index] <= 1'b1;
                r_dirty[r_victim][w_index] <= 1'b0;
            end
        end
    end

    // line data and tag storage; contents are don't-care after reset
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (w_hit_access && i_mem_write) begin
                for (int b = 0; b < 32; b++) begin
                    if (i_mem_byte_enable[b]) begin
                        r_data[w_hit_way][w_index][8*b +: 8] <= i_mem_wdata[8*b +: 8];
                    end
                end
            end else if (w_fill_done) begin
                r_data[r_victim][w_index] <= i_pmem_rdata;
                r_tag[r_victim][w_index]  <= w_tag;
            end
        end
    end

endmodule

// File: tb/tb_set_assoc_cache.sv
// tb_set_assoc_cache: directed table of cache requests in set 2 with hand-computed
// hit/miss, write-back and read-data expectations, plus reset-during-fill.
module tb_set_assoc_cache;

    localparam int LAT = 2;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic [31:0]  i_mem_address;
    logic         i_mem_read;
    logic         i_mem_write;
    logic [31:0]  i_mem_byte_enable;
    logic [255:0] i_mem_wdata;
    logic [255:0] o_mem_rdata;
    logic         o_mem_resp;
    logic [31:0]  o_pmem_address;
    logic         o_pmem_read;
    logic         o_pmem_write;
    logic [255:0] o_pmem_wdata;
    logic [255:0] i_pmem_rdata;
    logic         i_pmem_resp;

    int checks   = 0;
    int failures = 0;

    logic [255:0] backing [logic [31:0]];

    typedef struct {
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [31:0]  be;
        logic [255:0] wdata;
        logic         exp_hit;
        logic         exp_wb;
        logic [31:0]  wb_addr;
        logic [255:0] wb_data;
        logic [255:0] rdata;
    } vec_t;

    vec_t vecs[$];

    set_assoc_cache #(.S_INDEX(4), .WAYS(4)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_mem_address    (i_mem_address),
        .i_mem_read       (i_mem_read),
        .i_mem_write      (i_mem_write),
        .i_mem_byte_enable(i_mem_byte_enable),
        .i_mem_wdata      (i_mem_wdata),
        .o_mem_rdata      (o_mem_rdata),
        .o_mem_resp       (o_mem_resp),
        .o_pmem_address   (o_pmem_address),
        .o_pmem_read      (o_pmem_read),
        .o_pmem_write     (o_pmem_write),
        .o_pmem_wdata     (o_pmem_wdata),
        .i_pmem_rdata     (i_pmem_rdata),
        .i_pmem_resp      (i_pmem_resp)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [255:0] pat(input logic [31:0] a);
        logic [255:0] p;
        for (int i = 0; i < 8; i++) begin
            p[i*32 +: 32] = {a[31:5], 5'b0} ^ (32'(i) * 32'h1111_1111);
        end
        return p;
    endfunction

    function automatic logic [255:0] merge(input logic [255:0] old_line,
                                           input logic [255:0] new_line,
                                           input logic [31:0] be);
        logic [255:0] r;
        r = old_line;
        for (int b = 0; b < 32; b++) begin
            if (be[b]) r[8*b +: 8] = new_line[8*b +: 8];
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] a,
                                input logic [31:0] be, input logic [255:0] wd,
                                input logic hit, input logic wb, input logic [31:0] wba,
                                input logic [255:0] wbd, input logic [255:0] rdat);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = a; v.be = be; v.wdata = wd;
        v.exp_hit = hit; v.exp_wb = wb; v.wb_addr = wba; v.wb_data = wbd; v.rdata = rdat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int c, wait_c, resp_c, exp_c;
        logic done, saw_wb, saw_fill;
        logic [255:0] got;
        i_mem_address     = v.addr;
        i_mem_read        = v.rd;
        i_mem_write       = v.wr;
        i_mem_byte_enable = v.be;
        i_mem_wdata       = v.wdata;
        c = 0; wait_c = 0; resp_c = -1; done = 1'b0; saw_wb = 1'b0; saw_fill = 1'b0;
        got = '0;
        while (!done && c < 40) begin
            @(negedge i_clk);
            i_pmem_resp = 1'b0;
            chk($sformatf("v%0d_strobe_excl", id), o_pmem_read & o_pmem_write, 0);
            if (o_mem_resp) begin
                done   = 1'b1;
                resp_c = c;
                got    = o_mem_rdata;
            end else if (o_pmem_write) begin
                chk($sformatf("v%0d_wb_addr", id), o_pmem_address, v.wb_addr);
                if (!saw_wb) chk($sformatf("v%0d_wb_data", id), o_pmem_wdata, v.wb_data);
                saw_wb = 1'b1;
                wait_c++;
                if (wait_c == LAT) begin
                    backing[o_pmem_address] = o_pmem_wdata;
                    i_pmem_resp = 1'b1;
                    wait_c = 0;
                end
            end else if (o_pmem_read) begin
                chk($sformatf("v%0d_fill_addr", id), o_pmem_address, v.addr);
                saw_fill = 1'b1;
                wait_c++;
                if (wait_c == LAT) begin
                    i_pmem_rdata = backing.exists(o_pmem_address) ? backing[o_pmem_address]
                                                                  : pat(o_pmem_address);
                    i_pmem_resp = 1'b1;
                    wait_c = 0;
                end
            end
            c++;
        end
        exp_c = v.exp_hit ? 0 : (v.exp_wb ? 1 + 2 * LAT : 1 + LAT);
        chk($sformatf("v%0d_resp_seen", id), done, 1);
        chk($sformatf("v%0d_resp_cycle", id), resp_c, exp_c);
        chk($sformatf("v%0d_did_wb", id), saw_wb, v.exp_wb);
        chk($sformatf("v%0d_did_fill", id), saw_fill, !v.exp_hit);
        if (v.rd && !v.wr) chk($sformatf("v%0d_rdata", id), got, v.rdata);
        @(posedge i_clk);
        #1;
        i_mem_read  = 1'b0;
        i_mem_write = 1'b0;
        @(negedge i_clk);
        chk($sformatf("v%0d_resp_single", id), o_mem_resp, 0);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] aa, x55, x3c, m1, m55, m3c;
        int k;
        logic found;
        aa  = {32{8'hAA}};
        x55 = {32{8'h55}};
        x3c = {32{8'h3C}};
        m1  = merge(pat(32'h1040), aa, 32'h0000_000F);
        m55 = merge(pat(32'h1840), x55, 32'hFF00_0000);
        m3c = merge(pat(32'h1C40), x3c, 32'h0000_00F0);

        //                 rd    wr    addr        be            wdata hit   wb    wb_addr     wb_data rdata
        vecs.push_back(mk(1'b1, 1'b0, 32'h1040, 32'h0,         '0,  1'b0, 1'b0, 32'h0,    '0,  pat(32'h1040)));
        vecs.push_back(mk(1'b0, 1'b1, 32'h1040, 32'h0000_000F, aa,  1'b1, 1'b0, 32'h0,    '0,  '0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h1040, 32'h0,         '0,  1'b1, 1'b0, 32'h0,    '0,  m1));
        vecs.push_back(mk(1'b1, 1'b0, 32'h1240, 32'h0,         '0,  1'b0, 1'b0, 32'h0,    '0,  pat(32'h1240)));
        vecs.push_back(mk(1'b1, 1'b0, 32'h1440, 32'h0,         '0,  1'b0, 1'b0, 32'h0,    '0,  pat(32'h1440)));
        vecs.push_back(mk(1'b1, 1'b0, 32'h1640, 32'h0,         '0,  1'b0, 1'b0, 32'h0,    '0,  pat(32'h1640)));
        vecs.push_back(mk(1'b1, 1'b0, 32'h1040, 32'h0,         '0,  1'b1, 1'b0, 32'h0,    '0,  m1));
        vecs.push_back(mk(1'b1, 1'b0, 32'h1840, 32'h0,         '0,  1'b0, 1'b0, 32'h0,    '0,  pat(32'h1840)));
        vecs.push_back(mk(1'b0, 1'b1, 32'h1840, 32'hFF00_0000, x55, 1'b1, 1'b0, 32'h0,    '0,  '0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h1640, 32'h0,         '0,  1'b1, 1'b0, 32'h0,    '0,  pat(32'h1640)));
        vecs.push_back(mk(1'b1, 1'b0, 32'h1240, 32'h0,         '0,  1'b1, 1'b0, 32'h0,    '0,  pat(32'h1240)));
        vecs.push_back(mk(1'b1, 1'b0, 32'h1A40, 32'h0,         '0,  1'b0, 1'b1, 32'h1840, m55, pat(32'h1A40)));
        vecs.push_back(mk(1'b1, 1'b0, 32'h1440, 32'h0,         '0,  1'b0, 1'b1, 32'h1040, m1,  pat(32'h1440)));
        vecs.push_back(mk(1'b1, 1'b0, 32'h1840, 32'h0,         '0,  1'b0, 1'b0, 32'h0,    '0,  m55));
        vecs.push_back(mk(1'b1, 1'b0, 32'h1440, 32'h0,         '0,  1'b1, 1'b0, 32'h0,    '0,  pat(32'h1440)));
        vecs.push_back(mk(1'b1, 1'b0, 32'h1C40, 32'h0,         '0,  1'b0, 1'b0, 32'h0,    '0,  pat(32'h1C40)));
        vecs.push_back(mk(1'b1, 1'b1, 32'h1C40, 32'h0000_00F0, x3c, 1'b1, 1'b0, 32'h0,    '0,  '0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h1C40, 32'h0,         '0,  1'b1, 1'b0, 32'h0,    '0,  m3c));
        vecs.push_back(mk(1'b1, 1'b0, 32'h1840, 32'h0,         '0,  1'b1, 1'b0, 32'h0,    '0,  m55));
        vecs.push_back(mk(1'b1, 1'b0, 32'h1240, 32'h0,         '0,  1'b1, 1'b0, 32'h0,    '0,  pat(32'h1240)));
        vecs.push_back(mk(1'b1, 1'b0, 32'h1E40, 32'h0,         '0,  1'b0, 1'b1, 32'h1C40, m3c, pat(32'h1E40)));

        i_rst = 1'b1;
        i_mem_address = '0; i_mem_read = 1'b0; i_mem_write = 1'b0;
        i_mem_byte_enable = '0; i_mem_wdata = '0;
        i_pmem_rdata = '0; i_pmem_resp = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_mem_resp", o_mem_resp, 0);
        chk("rst_pmem_read", o_pmem_read, 0);
        chk("rst_pmem_write", o_pmem_write, 0);
        chk("rst_pmem_address", o_pmem_address, 0);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i + 1);
        end

        // reset while a fill is outstanding
        i_mem_address = 32'h2040;
        i_mem_read    = 1'b1;
        found = 1'b0;
        k = 0;
        while (!found && k < 20) begin
            @(negedge i_clk);
            if (o_pmem_read) found = 1'b1;
            k++;
        end
        chk("rstfill_reached_fill", found, 1);
        chk("rstfill_fill_addr", o_pmem_address, 32'h2040);
        i_rst      = 1'b1;
        i_mem_read = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        chk("rstfill_pmem_read", o_pmem_read, 0);
        chk("rstfill_pmem_write", o_pmem_write, 0);
        chk("rstfill_mem_resp", o_mem_resp, 0);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        run_vec(mk(1'b1, 1'b0, 32'h2040, 32'h0, '0, 1'b0, 1'b0, 32'h0, '0, pat(32'h2040)), 101);
        run_vec(mk(1'b1, 1'b0, 32'h1840, 32'h0, '0, 1'b0, 1'b0, 32'h0, '0, m55), 102);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
